// File: rtl/period_meter.sv
// rtl/period_meter.sv - period and high-time meter for an asynchronous square wave
module period_meter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sig_in,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         valid,
  output logic         timeout
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  state_t       state;
  state_t       state_nxt;

  logic         s1;
  logic         s2;
  logic         s3;
  logic         rise;
  logic         fall;

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;
  logic [W-1:0] hi_cnt;
  logic [W-1:0] hi_cnt_nxt;
  logic [W-1:0] period_nxt;
  logic [W-1:0] high_time_nxt;
  logic         valid_nxt;
  logic         timeout_nxt;

  // s1/s2 resolve metastability; s3 is the previous synchronized sample for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_cnt    <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hi_cnt    <= hi_cnt_nxt;
      period    <= period_nxt;
      high_time <= high_time_nxt;
      valid     <= valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    hi_cnt_nxt    = hi_cnt;
    period_nxt    = period;
    high_time_nxt = high_time;
    valid_nxt     = 1'b0;
    timeout_nxt   = timeout;

    case (state)
      IDLE: begin
        // first edge after reset or timeout only arms the counter
        if (rise) begin
          cnt_nxt     = CNT_ONE;
          hi_cnt_nxt  = '0;
          timeout_nxt = 1'b0;
          state_nxt   = MEASURE;
        end
      end

      MEASURE: begin
        // a rise on the saturating cycle still counts as a measurement
        if (rise) begin
          period_nxt    = cnt;
          high_time_nxt = hi_cnt;
          valid_nxt     = 1'b1;
          cnt_nxt       = CNT_ONE;
          hi_cnt_nxt    = '0;
        end else if (cnt == CNT_MAX) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
          if (fall) begin
            hi_cnt_nxt = cnt;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - directed self-checking bench for period_meter
module tb_period_meter;

  logic        clk;
  logic        rst_n;
  logic        sig16;
  logic        sig8;
  logic [15:0] period16;
  logic [15:0] high16;
  logic        valid16;
  logic        timeout16;
  logic [7:0]  period8;
  logic [7:0]  high8;
  logic        valid8;
  logic        timeout8;

  int          tests;
  int          fails;
  int          vcnt16;
  int          dbl16;
  int          vcnt8;
  logic        prev16;
  logic        to8_seen;
  logic [15:0] first_p16;
  logic [15:0] first_h16;
  logic [15:0] last_p16;
  logic [15:0] last_h16;

  period_meter #(.W(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig16),
    .period    (period16),
    .high_time (high16),
    .valid     (valid16),
    .timeout   (timeout16)
  );

  period_meter #(.W(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig8),
    .period    (period8),
    .high_time (high8),
    .valid     (valid8),
    .timeout   (timeout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // advance one clock and record valid pulses away from the edge
  task automatic step();
    @(posedge clk);
    #1;
    if (valid16) begin
      if (vcnt16 == 0) begin
        first_p16 = period16;
        first_h16 = high16;
      end
      vcnt16++;
      last_p16 = period16;
      last_h16 = high16;
      if (prev16) dbl16++;
    end
    prev16 = valid16;
    if (valid8) vcnt8++;
    if (timeout8) to8_seen = 1'b1;
  endtask

  initial begin
    tests = 0; fails = 0;
    vcnt16 = 0; dbl16 = 0; vcnt8 = 0;
    prev16 = 1'b0; to8_seen = 1'b0;
    first_p16 = '0; first_h16 = '0; last_p16 = '0; last_h16 = '0;
    rst_n = 1'b0; sig16 = 1'b0; sig8 = 1'b0;

    step(); step();
    check("reset_period16", 32'(period16), 32'd0);
    check("reset_high16", 32'(high16), 32'd0);
    check("reset_valid16", 32'(valid16), 32'd0);
    check("reset_timeout16", 32'(timeout16), 32'd0);
    check("reset_period8", 32'(period8), 32'd0);
    check("reset_timeout8", 32'(timeout8), 32'd0);
    rst_n = 1'b1;
    step(); step();

    // 20-cycle wave, 8 high / 12 low, four periods
    vcnt16 = 0; dbl16 = 0;
    for (int p = 0; p < 4; p++) begin
      sig16 = 1'b1; repeat (8) step();
      sig16 = 1'b0; repeat (12) step();
    end
    check("p20_valid_count", 32'(vcnt16), 32'd3);
    check("p20_no_back_to_back", 32'(dbl16), 32'd0);
    check("p20_period", 32'(last_p16), 32'd20);
    check("p20_high", 32'(last_h16), 32'd8);

    // switch to 6-cycle 3/3; the switch edge closes the last 20-cycle period
    sig16 = 1'b1; repeat (3) step();
    sig16 = 1'b0; repeat (3) step();
    check("switch_closes_p20", 32'(last_p16), 32'd20);
    vcnt16 = 0;
    for (int p = 0; p < 2; p++) begin
      sig16 = 1'b1; repeat (3) step();
      sig16 = 1'b0; repeat (3) step();
    end
    check("p6_first_period", 32'(first_p16), 32'd6);
    check("p6_first_high", 32'(first_h16), 32'd3);
    check("p6_valid_count", 32'(vcnt16), 32'd2);
    check("p6_no_back_to_back", 32'(dbl16), 32'd0);

    // W=8: one arming edge then low; timeout 255 cycles after the arming detection
    vcnt8 = 0; to8_seen = 1'b0;
    sig8 = 1'b1; step(); step();
    sig8 = 1'b0; repeat (255) step();
    check("to8_not_yet", 32'(timeout8), 32'd0);
    step();
    check("to8_set", 32'(timeout8), 32'd1);
    check("to8_period_held", 32'(period8), 32'd0);
    check("to8_no_valid", 32'(vcnt8), 32'd0);

    sig8 = 1'b1; step(); step();
    sig8 = 1'b0; step();
    check("to8_cleared_by_rise", 32'(timeout8), 32'd0);
    repeat (7) step();
    sig8 = 1'b1; repeat (3) step();
    check("re8_valid_count", 32'(vcnt8), 32'd1);
    check("re8_period", 32'(period8), 32'd10);
    check("re8_high", 32'(high8), 32'd2);

    // rises exactly 255 cycles apart: measurement wins over timeout
    to8_seen = 1'b0;
    sig8 = 1'b0; repeat (252) step();
    sig8 = 1'b1; repeat (3) step();
    check("max8_valid_count", 32'(vcnt8), 32'd2);
    check("max8_period", 32'(period8), 32'd255);
    check("max8_high", 32'(high8), 32'd3);
    check("max8_no_timeout", 32'(to8_seen), 32'd0);
    sig8 = 1'b0;

    // reset pulse in the middle of a period
    sig16 = 1'b1; repeat (4) step();
    rst_n = 1'b0;
    #2;
    check("async_rst_period16", 32'(period16), 32'd0);
    check("async_rst_high16", 32'(high16), 32'd0);
    check("async_rst_valid16", 32'(valid16), 32'd0);
    check("async_rst_timeout16", 32'(timeout16), 32'd0);
    check("async_rst_period8", 32'(period8), 32'd0);
    step();
    rst_n = 1'b1; sig16 = 1'b0;
    repeat (4) step();
    vcnt16 = 0;
    sig16 = 1'b1; repeat (5) step();
    sig16 = 1'b0; repeat (9) step();
    check("post_rst_arm_no_valid", 32'(vcnt16), 32'd0);
    sig16 = 1'b1; repeat (3) step();
    check("post_rst_valid_count", 32'(vcnt16), 32'd1);
    check("post_rst_period", 32'(period16), 32'd14);
    check("post_rst_high", 32'(high16), 32'd5);

    // sig_in high across reset release arms only
    sig16 = 1'b1; rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1; vcnt16 = 0;
    repeat (4) step();
    sig16 = 1'b0; repeat (6) step();
    check("high_rel_no_valid", 32'(vcnt16), 32'd0);
    sig16 = 1'b1; repeat (3) step();
    check("high_rel_valid_count", 32'(vcnt16), 32'd1);
    check("high_rel_period", 32'(period16), 32'd10);
    check("high_rel_high", 32'(high16), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
